// File: rtl/dpram_access_arbiter.sv
// dpram_access_arbiter
//   Shares one dual-port RAM (one write port, one read port) among NUM_REQ
//   requesters. Writes and reads are arbitrated by two independent
//   round-robin arbiters; read data is returned to the issuing requester.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-requester command handshake (ready is combinational)
//   req_we              1 = write, 0 = read
//   req_addr/req_wdata  packed per-requester address / write data
//   rsp_valid/rsp_rdata one-hot read-response strobe and its data
//   ram_wr_*            registered RAM write port
//   ram_rd_*            registered RAM read port, ram_rd_data valid RD_LAT
//                       cycles after ram_rd_en
module dpram_access_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      ram_wr_en,
    output logic [ADDR_W-1:0]         ram_wr_addr,
    output logic [DATA_W-1:0]         ram_wr_data,
    output logic                      ram_rd_en,
    output logic [ADDR_W-1:0]         ram_rd_addr,
    input  logic [DATA_W-1:0]         ram_rd_data
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    typedef logic [IDX_W-1:0] idx_t;

    // Returns {found, index} of the first candidate at or after ptr, wrapping.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                               input idx_t ptr);
        logic [IDX_W:0] sum;
        logic [IDX_W:0] res;
        res = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
            if (!res[IDX_W] && cand[sum[IDX_W-1:0]]) res = {1'b1, sum[IDX_W-1:0]};
        end
        return res;
    endfunction

    function automatic idx_t ptr_after(input idx_t w);
        return (w == idx_t'(NUM_REQ-1)) ? '0 : w + 1'b1;
    endfunction

    logic [IDX_W:0]     wr_pick, rd_pick;
    logic               wr_found, rd_found, rd_go;
    idx_t               wr_win, rd_win;
    idx_t               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]  wr_addr_sel, rd_addr_sel;
    logic [DATA_W-1:0]  wr_data_sel;

    logic               ram_wr_en_q, ram_rd_en_q;
    logic [ADDR_W-1:0]  ram_wr_addr_q, ram_rd_addr_q;
    logic [DATA_W-1:0]  ram_wr_data_q;
    idx_t               rd_id_q;
    logic               vld_pipe_q [RD_LAT];
    idx_t               id_pipe_q  [RD_LAT];
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q;

    always_comb begin
        wr_pick     = rr_pick(req_valid & req_we, wr_ptr_q);
        rd_pick     = rr_pick(req_valid & ~req_we, rd_ptr_q);
        wr_found    = wr_pick[IDX_W];
        wr_win      = wr_pick[IDX_W-1:0];
        rd_found    = rd_pick[IDX_W];
        rd_win      = rd_pick[IDX_W-1:0];
        wr_addr_sel = '0;
        wr_data_sel = '0;
        rd_addr_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (idx_t'(i) == wr_win) begin
                wr_addr_sel = req_addr[i*ADDR_W +: ADDR_W];
                wr_data_sel = req_wdata[i*DATA_W +: DATA_W];
            end
            if (idx_t'(i) == rd_win) rd_addr_sel = req_addr[i*ADDR_W +: ADDR_W];
        end
        // Same-address write and read in one cycle: hold the read back so it
        // re-arbitrates next cycle and observes the freshly written data.
        rd_go = rd_found && !(wr_found && (wr_addr_sel == rd_addr_sel));
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (wr_found && (idx_t'(i) == wr_win)) ||
                           (rd_go && (idx_t'(i) == rd_win));
        end
        wr_ptr_d = wr_found ? ptr_after(wr_win) : wr_ptr_q;
        rd_ptr_d = rd_go    ? ptr_after(rd_win) : rd_ptr_q;
        rsp_valid_d = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (vld_pipe_q[RD_LAT-1] && (id_pipe_q[RD_LAT-1] == idx_t'(i))) rsp_valid_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ram_wr_en_q   <= 1'b0;
            ram_wr_addr_q <= '0;
            ram_wr_data_q <= '0;
            ram_rd_en_q   <= 1'b0;
            ram_rd_addr_q <= '0;
            rd_id_q       <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            for (int unsigned s = 0; s < RD_LAT; s++) begin
                vld_pipe_q[s] <= 1'b0;
                id_pipe_q[s]  <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_wr_en_q <= wr_found;
            if (wr_found) begin
                ram_wr_addr_q <= wr_addr_sel;
                ram_wr_data_q <= wr_data_sel;
            end
            ram_rd_en_q <= rd_go;
            if (rd_go) begin
                ram_rd_addr_q <= rd_addr_sel;
                rd_id_q       <= rd_win;
            end
            // Stage s holds the read issued s+1 cycles ago; the last stage
            // lines up with valid ram_rd_data.
            vld_pipe_q[0] <= ram_rd_en_q;
            id_pipe_q[0]  <= rd_id_q;
            for (int unsigned s = 1; s < RD_LAT; s++) begin
                vld_pipe_q[s] <= vld_pipe_q[s-1];
                id_pipe_q[s]  <= id_pipe_q[s-1];
            end
            rsp_valid_q <= rsp_valid_d;
            if (vld_pipe_q[RD_LAT-1]) rsp_rdata_q <= ram_rd_data;
        end
    end

    assign ram_wr_en   = ram_wr_en_q;
    assign ram_wr_addr = ram_wr_addr_q;
    assign ram_wr_data = ram_wr_data_q;
    assign ram_rd_en   = ram_rd_en_q;
    assign ram_rd_addr = ram_rd_addr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_dpram_access_arbiter.sv
// tb_dpram_access_arbiter
//   Scoreboard bench: a RD_LAT=1 instance with a behavioural RAM carries most
//   scenarios, a RD_LAT=3 instance covers the longer read latency.
module tb_dpram_access_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- RD_LAT = 1 instance ----------------
    logic [3:0]  valid = '0, we = '0, req_ready, rsp_valid;
    logic [31:0] addr = '0, wdata = '0;
    logic [7:0]  rsp_rdata, ram_wr_addr, ram_wr_data, ram_rd_addr, ram_rd_data;
    logic        ram_wr_en, ram_rd_en;

    dpram_access_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .req_valid(valid), .req_ready(req_ready), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    // ---------------- RD_LAT = 3 instance ----------------
    logic [3:0]  v3 = '0, we3 = '0, ready3, rsp_valid3;
    logic [31:0] a3 = '0, d3 = '0;
    logic [7:0]  rsp_rdata3, ram_wr_addr3, ram_wr_data3, ram_rd_addr3, ram_rd_data3;
    logic        ram_wr_en3, ram_rd_en3;

    dpram_access_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_ready(ready3), .req_we(we3),
        .req_addr(a3), .req_wdata(d3), .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3),
        .ram_wr_en(ram_wr_en3), .ram_wr_addr(ram_wr_addr3), .ram_wr_data(ram_wr_data3),
        .ram_rd_en(ram_rd_en3), .ram_rd_addr(ram_rd_addr3), .ram_rd_data(ram_rd_data3)
    );

    // Behavioural RAMs: read data appears RD_LAT cycles after the read address.
    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];
    logic [7:0] r1;
    logic [7:0] r3 [3];
    always @(posedge clk) begin
        if (ram_wr_en) mem1[ram_wr_addr] <= ram_wr_data;
        r1 <= mem1[ram_rd_addr];
        if (ram_wr_en3) mem3[ram_wr_addr3] <= ram_wr_data3;
        r3[0] <= mem3[ram_rd_addr3];
        r3[1] <= r3[0];
        r3[2] <= r3[1];
    end
    assign ram_rd_data  = r1;
    assign ram_rd_data3 = r3[2];

    // ---------------- scoreboard (RD_LAT = 1 instance) ----------------
    typedef struct { int cyc; logic [7:0] a; logic [7:0] d; } port_t;
    typedef struct { int cyc; int id; logic [7:0] d; } rsp_t;
    port_t wq[$];
    port_t rq[$];
    rsp_t  sq[$];
    logic [7:0] shadow [256];

    always @(negedge clk) begin
        port_t p;
        rsp_t  s;
        if (rst) begin
            wq.delete(); rq.delete(); sq.delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (valid[i] && req_ready[i]) begin
                    if (we[i]) begin
                        shadow[addr[i*8 +: 8]] = wdata[i*8 +: 8];
                        wq.push_back('{cyc + 1, addr[i*8 +: 8], wdata[i*8 +: 8]});
                    end else begin
                        rq.push_back('{cyc + 1, addr[i*8 +: 8], 8'h00});
                        sq.push_back('{cyc + 3, i, shadow[addr[i*8 +: 8]]});
                    end
                end
            end
            if (ram_wr_en) begin
                if (wq.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
                else begin
                    p = wq.pop_front();
                    check("wr_cycle", cyc, p.cyc);
                    check("wr_addr", {24'd0, ram_wr_addr}, {24'd0, p.a});
                    check("wr_data", {24'd0, ram_wr_data}, {24'd0, p.d});
                end
            end
            if (ram_rd_en) begin
                if (rq.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
                else begin
                    p = rq.pop_front();
                    check("rd_cycle", cyc, p.cyc);
                    check("rd_addr", {24'd0, ram_rd_addr}, {24'd0, p.a});
                end
            end
            if (rsp_valid != 4'b0) begin
                if (sq.size() == 0) check("rsp_unexpected", {28'd0, rsp_valid}, 32'd0);
                else begin
                    s = sq.pop_front();
                    check("rsp_cycle", cyc, s.cyc);
                    check("rsp_id", {28'd0, rsp_valid}, 32'd1 << s.id);
                    check("rsp_data", {24'd0, rsp_rdata}, {24'd0, s.d});
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic put(input int i, input bit v, input bit w, input logic [7:0] a, input logic [7:0] d);
        valid[i]       = v;
        we[i]          = w;
        addr[i*8 +: 8]  = a;
        wdata[i*8 +: 8] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // All four requesters contend; pointer at 0 must grant 0,1,2,3.
    task automatic arb_round(input bit is_we, input logic [7:0] base);
        for (int i = 0; i < 4; i++) put(i, 1'b1, is_we, base + 8'(i), 8'h90 + 8'(i));
        for (int k = 0; k < 4; k++) begin
            smp();
            check(is_we ? "t5_wr_grant" : "t5_rd_grant", {28'd0, req_ready}, 32'd1 << k);
            tick();
            put(k, 1'b0, 1'b0, 8'h00, 8'h00);
        end
    endtask

    initial begin
        int t6;
        // Reset values
        do_reset();
        smp();
        check("rst_wr_en",   {31'd0, ram_wr_en}, 32'd0);
        check("rst_rd_en",   {31'd0, ram_rd_en}, 32'd0);
        check("rst_rsp",     {28'd0, rsp_valid}, 32'd0);
        check("rst_wr_addr", {24'd0, ram_wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, ram_wr_data}, 32'd0);
        check("rst_rd_addr", {24'd0, ram_rd_addr}, 32'd0);
        check("rst_rdata",   {24'd0, rsp_rdata}, 32'd0);
        check("rst_ready",   {28'd0, req_ready}, 32'd0);

        // 1. single write then read-back
        tick();
        put(0, 1'b1, 1'b1, 8'h10, 8'hA5);
        smp(); check("t1_wr_ready", {28'd0, req_ready}, 32'h1);
        tick(); put(0, 1'b0, 1'b0, 8'h00, 8'h00);
        smp();
        check("t1_wr_en",   {31'd0, ram_wr_en}, 32'd1);
        check("t1_wr_addr", {24'd0, ram_wr_addr}, 32'h10);
        check("t1_wr_data", {24'd0, ram_wr_data}, 32'hA5);
        tick(); put(0, 1'b1, 1'b0, 8'h10, 8'h00);
        smp(); check("t1_rd_ready", {28'd0, req_ready}, 32'h1);
        tick(); put(0, 1'b0, 1'b0, 8'h00, 8'h00);
        smp(); check("t1_rsp_early1", {28'd0, rsp_valid}, 32'h0);
        tick(); smp(); check("t1_rsp_early2", {28'd0, rsp_valid}, 32'h0);
        tick(); smp();
        check("t1_rsp_valid", {28'd0, rsp_valid}, 32'h1);
        check("t1_rsp_data",  {24'd0, rsp_rdata}, 32'hA5);
        tick();

        // Preload addresses 0..3 with 0x50+i
        for (int i = 0; i < 4; i++) put(i, 1'b1, 1'b1, 8'(i), 8'h50 + 8'(i));
        for (int c = 0; c < 10 && valid != 4'b0; c++) begin
            smp();
            for (int i = 0; i < 4; i++) if (req_ready[i]) valid[i] = 1'b0;
            tick();
        end
        check("preload_done", {28'd0, valid}, 32'h0);
        repeat (2) tick();

        // 2. four readers contending from a fresh pointer
        do_reset();
        for (int i = 0; i < 4; i++) put(i, 1'b1, 1'b0, 8'(i), 8'h00);
        for (int k = 0; k < 8; k++) begin
            smp(); check("t2_grant", {28'd0, req_ready}, 32'd1 << (k % 4));
            tick();
        end
        valid = '0;
        repeat (6) tick();

        // 3. write/read collision, then different addresses
        put(1, 1'b1, 1'b1, 8'h20, 8'h3C);
        put(2, 1'b1, 1'b0, 8'h20, 8'h00);
        smp(); check("t3_collide_ready", {28'd0, req_ready}, 32'h2);
        tick(); put(1, 1'b0, 1'b0, 8'h00, 8'h00);
        smp(); check("t3_retry_ready", {28'd0, req_ready}, 32'h4);
        tick(); put(2, 1'b0, 1'b0, 8'h00, 8'h00);
        put(1, 1'b1, 1'b1, 8'h21, 8'h5A);
        smp(); check("t3_pre_ready", {28'd0, req_ready}, 32'h2);
        tick();
        put(1, 1'b1, 1'b1, 8'h20, 8'h3D);
        put(2, 1'b1, 1'b0, 8'h21, 8'h00);
        smp(); check("t3_both_ready", {28'd0, req_ready}, 32'h6);
        tick(); valid = '0;
        repeat (5) tick();

        // 4. concurrent streaming writer and reader
        for (int k = 0; k < 6; k++) begin
            put(0, 1'b1, 1'b1, 8'h30 + 8'(k), 8'hC0 + 8'(k));
            put(3, 1'b1, 1'b0, (k == 0) ? 8'h10 : 8'h2F + 8'(k), 8'h00);
            smp(); check("t4_ready", {28'd0, req_ready}, 32'h9);
            if (k > 0) check("t4_both_en", {30'd0, ram_wr_en, ram_rd_en}, 32'h3);
            tick();
        end
        valid = '0;
        smp(); check("t4_tail_en", {30'd0, ram_wr_en, ram_rd_en}, 32'h3);
        repeat (5) tick();

        // 5. reset with two reads in flight
        put(1, 1'b1, 1'b0, 8'h10, 8'h00);
        put(2, 1'b1, 1'b0, 8'h20, 8'h00);
        smp(); check("t5_rd1_ready", {28'd0, req_ready}, 32'h2);
        tick(); put(1, 1'b0, 1'b0, 8'h00, 8'h00);
        smp(); check("t5_rd2_ready", {28'd0, req_ready}, 32'h4);
        tick(); put(2, 1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            smp(); check("t5_no_rsp", {28'd0, rsp_valid}, 32'h0);
            tick();
        end
        arb_round(1'b0, 8'h00);
        arb_round(1'b1, 8'h60);
        repeat (6) tick();

        // 6. RD_LAT = 3 instance
        v3 = 4'b0100; we3 = 4'b0100; a3[16 +: 8] = 8'h05; d3[16 +: 8] = 8'h77;
        smp(); check("t6_wr_ready", {28'd0, ready3}, 32'h4);
        tick(); v3 = '0;
        smp();
        check("t6_wr_en",   {31'd0, ram_wr_en3}, 32'd1);
        check("t6_wr_addr", {24'd0, ram_wr_addr3}, 32'h05);
        repeat (2) tick();
        v3 = 4'b0100; we3 = 4'b0000;
        smp(); check("t6_rd_ready", {28'd0, ready3}, 32'h4);
        t6 = cyc;
        tick(); v3 = '0;
        for (int j = 1; j <= 8; j++) begin
            smp();
            check("t6_rsp_valid", {28'd0, rsp_valid3}, (cyc == t6 + 5) ? 32'h4 : 32'h0);
            if (cyc == t6 + 5) check("t6_rsp_data", {24'd0, rsp_rdata3}, 32'h77);
            tick();
        end

        check("sb_drained", sq.size() + wq.size() + rq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
